// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, inst SRAM request,
// FS register and a one-entry hold buffer for decode stalls.
//
// Ports:
//   clk, reset (async, active-low)
//   ds_allowin      : decode can take an instruction this cycle
//   br_bus          : {br_taken, br_target[31:0]} from decode
//   fs_to_ds_valid  : FS holds a valid instruction for decode
//   fs_to_ds_bus    : {fs_pc[31:0], fs_inst[31:0]}
//   inst_sram_*     : instruction SRAM port, rdata one cycle after en

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;

    logic        to_fs_valid;
    logic        fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;

    logic        rdata_fresh;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic        buf_load;

    assign {br_taken, br_target} = br_bus;

    assign seq_pc = fs_pc + 32'd4;
    assign nextpc = br_taken ? br_target : seq_pc;

    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

    assign fs_to_ds_valid = fs_valid & fs_ready_go;

    // SRAM data is only held for one cycle; on the first stall cycle it
    // is captured so the FS bundle stays stable for the rest of the stall.
    assign buf_load = fs_valid & rdata_fresh
                    & ~ds_allowin & ~inst_buf_valid;

    assign fs_inst      = inst_buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_bus = {fs_pc, fs_inst};

    // Pre-IF valid: rises on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_fs_valid <= 1'b0;
        end else begin
            to_fs_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (inst_sram_en) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end else if (fs_allowin) begin
            fs_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_fresh <= 1'b0;
        end else begin
            rdata_fresh <= inst_sram_en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'b0;
        end else if (inst_sram_en) begin
            inst_buf_valid <= 1'b0;
        end else if (buf_load) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: SRAM responder, expected fetch bundles queued
// at request time and compared when FS presents them to decode.

module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        w_valid;
    logic [63:0] w_bus;
    logic        w_en;
    logic [3:0]  w_wen;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    logic [63:0] sbq[$];
    int          chk;
    int          pass;

    if_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (w_valid),
        .fs_to_ds_bus   (w_bus),
        .inst_sram_en   (w_en),
        .inst_sram_wen  (w_wen),
        .inst_sram_addr (w_addr),
        .inst_sram_wdata(w_wdata),
        .inst_sram_rdata(w_rdata)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM responder: data for the requested address in the next cycle,
    // garbage whenever no request was made.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? f(inst_sram_addr) : $urandom;
        w_rdata         <= w_en ? f(w_addr) : $urandom;
    end

    task automatic sb_update(input logic req, input logic [31:0] a);
        if (fs_to_ds_valid && ds_allowin && sbq.size() > 0)
            void'(sbq.pop_front());
        if (req)
            sbq.push_back({a, f(a)});
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = '0;
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = '0;
        sbq.delete();
        @(negedge clk);
        #1;
        chk++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0
            || inst_sram_addr !== 32'hBFC0_0000)
            $display("FAIL rst_out: v=%b en=%b addr=%h exp v=0 en=0 addr=bfc00000",
                     fs_to_ds_valid, inst_sram_en, inst_sram_addr);
        else pass++;
        chk++;
        if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0)
            $display("FAIL rst_tie: wen=%h wdata=%h exp 0 0",
                     inst_sram_wen, inst_sram_wdata);
        else pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk++;
        if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0)
            $display("FAIL rst_c0: en=%b v=%b exp en=0 v=0",
                     inst_sram_en, fs_to_ds_valid);
        else pass++;
    endtask

    task automatic test_seq();
        logic [31:0] ea [3];
        logic [63:0] eb;
        logic        ev;
        ea[0] = 32'hBFC0_0000;
        ea[1] = 32'hBFC0_0004;
        ea[2] = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ds_allowin = 1'b1;
            br_bus     = '0;
            #1;
            ev = (i > 0);
            eb = (sbq.size() > 0) ? sbq[0] : 64'hx;
            chk++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== ea[i])
                $display("FAIL seq_req c%0d: en=%b addr=%h exp en=1 addr=%h",
                         i, inst_sram_en, inst_sram_addr, ea[i]);
            else pass++;
            chk++;
            if (fs_to_ds_valid !== ev || (ev && fs_to_ds_bus !== eb))
                $display("FAIL seq_bus c%0d: v=%b bus=%h exp v=%b bus=%h",
                         i, fs_to_ds_valid, fs_to_ds_bus, ev, eb);
            else pass++;
            sb_update(1'b1, ea[i]);
        end
    endtask

    task automatic test_stall();
        logic [3:0]  al;
        logic [63:0] eb;
        al = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ds_allowin = al[i];
            br_bus     = '0;
            #1;
            eb = (sbq.size() > 0) ? sbq[0] : 64'hx;
            chk++;
            if (inst_sram_en !== al[i]
                || (al[i] && inst_sram_addr !== 32'hBFC0_000C))
                $display("FAIL stall_req c%0d: en=%b addr=%h exp en=%b addr=bfc0000c",
                         i, inst_sram_en, inst_sram_addr, al[i]);
            else pass++;
            chk++;
            if (fs_to_ds_valid !== 1'b1
                || fs_to_ds_bus !== {32'hBFC0_0008, f(32'hBFC0_0008)}
                || fs_to_ds_bus !== eb)
                $display("FAIL stall_bus c%0d: v=%b bus=%h exp v=1 bus=%h",
                         i, fs_to_ds_valid, fs_to_ds_bus, eb);
            else pass++;
            sb_update(al[i], 32'hBFC0_000C);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ea [6];
        logic [63:0] eb;
        logic        ev;
        ea[0] = 32'hBFC0_0000;
        ea[1] = 32'hBFC0_0004;
        ea[2] = 32'hBFC0_0008;
        ea[3] = 32'hBFC0_0100;
        ea[4] = 32'hBFC0_0104;
        ea[5] = 32'hBFC0_0108;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ds_allowin = 1'b1;
            br_bus     = (i == 3) ? {1'b1, 32'hBFC0_0100} : 33'b0;
            #1;
            ev = (i > 0);
            eb = (sbq.size() > 0) ? sbq[0] : 64'hx;
            chk++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== ea[i])
                $display("FAIL br_req c%0d: en=%b addr=%h exp en=1 addr=%h",
                         i, inst_sram_en, inst_sram_addr, ea[i]);
            else pass++;
            chk++;
            if (fs_to_ds_valid !== ev || (ev && fs_to_ds_bus !== eb))
                $display("FAIL br_bus c%0d: v=%b bus=%h exp v=%b bus=%h",
                         i, fs_to_ds_valid, fs_to_ds_bus, ev, eb);
            else pass++;
            sb_update(1'b1, ea[i]);
        end
    endtask

    task automatic test_branch_stall();
        logic [3:0]  al;
        logic [3:0]  bt;
        logic [31:0] ea [4];
        logic [63:0] eb;
        al = 4'b1100;
        bt = 4'b0111;
        ea[0] = 32'h0;
        ea[1] = 32'h0;
        ea[2] = 32'hBFC0_0200;
        ea[3] = 32'hBFC0_0204;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ds_allowin = al[i];
            br_bus     = {bt[i], 32'hBFC0_0200};
            #1;
            eb = (sbq.size() > 0) ? sbq[0] : 64'hx;
            chk++;
            if (inst_sram_en !== al[i]
                || (al[i] && inst_sram_addr !== ea[i]))
                $display("FAIL brst_req c%0d: en=%b addr=%h exp en=%b addr=%h",
                         i, inst_sram_en, inst_sram_addr, al[i], ea[i]);
            else pass++;
            chk++;
            if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== eb)
                $display("FAIL brst_bus c%0d: v=%b bus=%h exp v=1 bus=%h",
                         i, fs_to_ds_valid, fs_to_ds_bus, eb);
            else pass++;
            sb_update(al[i], ea[i]);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] eb;
        logic        ev;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ds_allowin = 1'b0;
            br_bus     = '0;
            #1;
            eb = (sbq.size() > 0) ? sbq[0] : 64'hx;
            chk++;
            if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b1
                || fs_to_ds_bus !== eb)
                $display("FAIL mid_stall c%0d: en=%b v=%b bus=%h exp en=0 v=1 bus=%h",
                         i, inst_sram_en, fs_to_ds_valid, fs_to_ds_bus, eb);
            else pass++;
        end
        #2;
        reset = 1'b0;
        sbq.delete();
        #1;
        chk++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0
            || inst_sram_addr !== 32'hBFC0_0000)
            $display("FAIL mid_rst: v=%b en=%b addr=%h exp v=0 en=0 addr=bfc00000",
                     fs_to_ds_valid, inst_sram_en, inst_sram_addr);
        else pass++;
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b1;
        ds_allowin = 1'b1;
        #1;
        chk++;
        if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0)
            $display("FAIL mid_c0: en=%b v=%b exp en=0 v=0",
                     inst_sram_en, fs_to_ds_valid);
        else pass++;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            ev = (i > 1);
            eb = (sbq.size() > 0) ? sbq[0] : 64'hx;
            chk++;
            if (inst_sram_en !== 1'b1
                || inst_sram_addr !== 32'hBFC0_0000 + 32'(4 * (i - 1)))
                $display("FAIL mid_req c%0d: en=%b addr=%h exp en=1 addr=%h",
                         i, inst_sram_en, inst_sram_addr,
                         32'hBFC0_0000 + 32'(4 * (i - 1)));
            else pass++;
            chk++;
            if (fs_to_ds_valid !== ev || (ev && fs_to_ds_bus !== eb))
                $display("FAIL mid_bus c%0d: v=%b bus=%h exp v=%b bus=%h",
                         i, fs_to_ds_valid, fs_to_ds_bus, ev, eb);
            else pass++;
            sb_update(1'b1, 32'hBFC0_0000 + 32'(4 * (i - 1)));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [3];
        logic [63:0] eb [3];
        ea[0] = 32'hFFFF_FFFC;
        ea[1] = 32'h0000_0000;
        ea[2] = 32'h0000_0004;
        eb[0] = 64'h0;
        eb[1] = {32'hFFFF_FFFC, f(32'hFFFF_FFFC)};
        eb[2] = {32'h0000_0000, f(32'h0000_0000)};
        do_reset();
        #1;
        chk++;
        if (w_en !== 1'b0 || w_valid !== 1'b0)
            $display("FAIL wrap_c0: en=%b v=%b exp en=0 v=0", w_en, w_valid);
        else pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk++;
            if (w_en !== 1'b1 || w_addr !== ea[i])
                $display("FAIL wrap_req c%0d: en=%b addr=%h exp en=1 addr=%h",
                         i, w_en, w_addr, ea[i]);
            else pass++;
            if (i > 0) begin
                chk++;
                if (w_valid !== 1'b1 || w_bus !== eb[i])
                    $display("FAIL wrap_bus c%0d: v=%b bus=%h exp v=1 bus=%h",
                             i, w_valid, w_bus, eb[i]);
                else pass++;
            end
        end
    endtask

    initial begin
        chk        = 0;
        pass       = 0;
        reset      = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = '0;
        test_reset();
        test_seq();
        test_stall();
        test_branch();
        test_branch_stall();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It sits upstream of the decode stage and drives the decode stage's input side: it produces `fs_to_ds_valid`/`fs_to_ds_bus` under the `ds_allowin` handshake and consumes the branch redirect bus `br_bus`. It contains a pre-IF next-PC generator, the instruction SRAM request port, the FS pipeline register, and a one-entry instruction hold buffer that covers decode back-pressure.

## Interface
- `RESET_PC`, 32'hBFC0_0000, address of the first instruction fetched after reset.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = in reset).
- `ds_allowin` input 1: the decode stage can accept an instruction this cycle.
- `br_bus` input 33: `{br_taken, br_target[31:0]}` from decode; already qualified by decode-valid.
- `fs_to_ds_valid` output 1: FS holds a valid instruction for decode.
- `fs_to_ds_bus` output 64: `{fs_pc[31:0], fs_inst[31:0]}`.
- `inst_sram_en` output 1: read request this cycle.
- `inst_sram_wen` output 4: tied to 4'b0.
- `inst_sram_addr` output 32: request address (= nextpc).
- `inst_sram_wdata` output 32: tied to 32'b0.
- `inst_sram_rdata` input 32: read data, valid only in the cycle after the cycle `inst_sram_en` was high.

## Operation
- Pre-IF: `to_fs_valid` is a register, 0 in reset, and is 1 from the first edge after reset release onward.
- `seq_pc = fs_pc + 4` (32-bit, wraps modulo 2^32). `nextpc = br_taken ? br_target : seq_pc`.
- `fs_ready_go = 1`. `fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin)`.
- `inst_sram_en = to_fs_valid & fs_allowin`. `inst_sram_addr = nextpc`.
- On an edge with `inst_sram_en=1`: `fs_valid<=1`, `fs_pc<=nextpc`, `inst_buf_valid<=0`.
- On an edge with `fs_allowin=1` and `to_fs_valid=0`: `fs_valid<=0`.
- `fs_to_ds_valid = fs_valid & fs_ready_go`.
- Hold buffer:
  - `rdata_fresh` is a register set to `inst_sram_en` every edge.
  - When `fs_valid & rdata_fresh & ~ds_allowin & ~inst_buf_valid`: `inst_buf<=inst_sram_rdata`, `inst_buf_valid<=1`.
  - `fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata`.
- Branch delay slot: the instruction in FS while the branch is in decode is the delay slot. It is never squashed. The redirect takes effect on the request issued in a cycle where `br_taken=1` and `inst_sram_en=1`. `br_taken` asserted while `inst_sram_en=0` causes no state change; decode keeps it asserted until the branch leaves decode.

## Timing
- Reset values: `fs_valid=0`, `fs_pc=RESET_PC-4`, `to_fs_valid=0`, `inst_buf_valid=0`, `rdata_fresh=0`, `inst_buf=0`.
- Outputs during reset: `fs_to_ds_valid=0`, `inst_sram_en=0`, `inst_sram_addr=RESET_PC`.
- Cycle 0 after release: `inst_sram_en=0`.
- Cycle 1 after release: request to `RESET_PC`.
- Cycle 2 after release: `fs_to_ds_valid=1`, `fs_pc=RESET_PC`, `fs_inst` is the SRAM data.
- Latency: request to FS-valid is 1 cycle. Steady-state throughput is one instruction per cycle when `ds_allowin=1`.
- Back-pressure:
  - While `ds_allowin=0` and `fs_valid=1`: no request is issued, and `fs_to_ds_bus` is stable cycle to cycle.
  - The buffered instruction is used from the second stall cycle onward.
- FS to decode transfer occurs on the edge with `fs_to_ds_valid & ds_allowin`.
- Reset asserted mid-operation clears all state asynchronously. Any SRAM response after reset is ignored, and the sequence restarts at `RESET_PC`.

## Test plan
- Reset release, `ds_allowin=1`, SRAM returns addr-derived data -> requests at 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; `fs_to_ds_bus` follows one cycle later with matching PC and instruction.
- Stall: drop `ds_allowin` for 3 cycles while FS holds pc 0xBFC00008 -> `inst_sram_en=0` for 3 cycles; `fs_to_ds_bus` holds `{0xBFC00008, inst}`, including cycles where SRAM rdata is driven to garbage; resume -> next request is 0xBFC0000C.
- Branch: `br_bus={1,0xBFC00100}` for one cycle with `ds_allowin=1` while FS holds the delay slot 0xBFC00008 -> the delay slot is handed to decode; the next request and FS PC are 0xBFC00100, then 0xBFC00104.
- Branch under stall: `br_taken=1` for 2 cycles with `ds_allowin=0`, then 1 cycle with `ds_allowin=1` -> exactly one redirect, on the release cycle; no request while stalled.
- Async reset asserted mid-stall with `inst_buf_valid=1` -> all outputs reach reset values immediately; after release, fetch restarts at 0xBFC00000.
- Wrap: with `RESET_PC=32'hFFFF_FFFC` -> requests 0xFFFFFFFC then 0x00000000.
